// File: rtl/apb_mem_pkg.sv
// Shared decode constants, FSM states and offset decoder for the APB memory slave.
package apb_mem_pkg;

    localparam logic [11:0] OFF_CTRL   = 12'hF00;
    localparam logic [11:0] OFF_WRCNT  = 12'hF04;
    localparam logic [11:0] OFF_RDCNT  = 12'hF08;
    localparam logic [11:0] OFF_ERRCNT = 12'hF0C;
    localparam logic [11:0] MEM_TOP    = 12'h3FF;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_e;

    typedef struct packed {
        logic is_mem;
        logic is_reg;
        logic is_err;
    } dec_t;

    // Misaligned offsets are errors even inside the memory window.
    function automatic dec_t decode_offset(input logic [11:0] off);
        dec_t d;
        d = '0;
        if (off[1:0] != 2'b00)
            d.is_err = 1'b1;
        else if (off <= MEM_TOP)
            d.is_mem = 1'b1;
        else if (off inside {OFF_CTRL, OFF_WRCNT, OFF_RDCNT, OFF_ERRCNT})
            d.is_reg = 1'b1;
        else
            d.is_err = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/apb_mem_if.sv
// APB completer-side bus bundle; signal names carry the slave's port direction.
interface apb_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [DATA_WIDTH-1:0] pwdata_i;
    logic [DATA_WIDTH-1:0] prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_mem_array.sv
// Single-port word RAM, synchronous write and registered read; macro drop-in point.
module apb_mem_array #(
    parameter int DEPTH_LG2  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DEPTH_LG2-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LG2];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else      rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/apb_mem_slave.sv
// APB slave: word SRAM window plus CTRL/counter bank, programmable wait states.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH_LG2 = 8,
    parameter int WAIT_DEFAULT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    apb_mem_if.slave   bus
);
    state_e                  state_q, state_d;
    logic [11:0]             addr_q, addr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   reg_rdata_q, reg_rdata_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [3:0]              ctrl_wait_q, ctrl_wait_d;
    dec_t                    dec_q, dec_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [DATA_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [DATA_WIDTH-1:0]   err_cnt_q, err_cnt_d;

    logic                     setup, access, mem_en, mem_we, pready;
    logic [11:0]              off;
    logic [MEM_DEPTH_LG2-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     unused_hi;

    assign off       = bus.paddr_i[11:0];
    assign unused_hi = ^bus.paddr_i[ADDR_WIDTH-1:12];
    assign setup     = bus.psel_i & ~bus.penable_i;
    assign access    = bus.psel_i & bus.penable_i;
    // RAM is read at setup with the live address, written at completion with the latched one.
    assign mem_addr  = (state_q == S_IDLE) ? off[MEM_DEPTH_LG2+1:2] : addr_q[MEM_DEPTH_LG2+1:2];

    apb_mem_array #(.DEPTH_LG2(MEM_DEPTH_LG2), .DATA_WIDTH(DATA_WIDTH)) u_array (
        .clk     (clk),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pwrite_d    = pwrite_q;
        wdata_d     = wdata_q;
        reg_rdata_d = reg_rdata_q;
        wcnt_d      = wcnt_q;
        ctrl_wait_d = ctrl_wait_q;
        dec_d       = dec_q;
        ready_d     = 1'b0;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_cnt_d   = err_cnt_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: if (setup) begin
                addr_d   = off;
                pwrite_d = bus.pwrite_i;
                wdata_d  = bus.pwdata_i;
                wcnt_d   = ctrl_wait_q;
                dec_d    = decode_offset(off);
                mem_en   = 1'b1;
                case (off)
                    OFF_CTRL:   reg_rdata_d = DATA_WIDTH'(ctrl_wait_q);
                    OFF_WRCNT:  reg_rdata_d = wr_cnt_q;
                    OFF_RDCNT:  reg_rdata_d = rd_cnt_q;
                    OFF_ERRCNT: reg_rdata_d = err_cnt_q;
                    default:    reg_rdata_d = '0;
                endcase
                if (ctrl_wait_q == 4'd0) begin
                    state_d = S_READY;
                    ready_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!access) begin
                    state_d   = S_IDLE;
                    err_cnt_d = err_cnt_q + DATA_WIDTH'(1);
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_d = S_READY;
                        ready_d = 1'b1;
                    end
                end
            end
            S_READY: begin
                state_d = S_IDLE;
                if (!access || dec_q.is_err) begin
                    err_cnt_d = err_cnt_q + DATA_WIDTH'(1);
                end else if (!pwrite_q) begin
                    rd_cnt_d = rd_cnt_q + DATA_WIDTH'(1);
                end else if (dec_q.is_mem) begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + DATA_WIDTH'(1);
                end else if (dec_q.is_reg) begin
                    // Counter writes are clears and are not themselves counted.
                    case (addr_q)
                        OFF_CTRL: begin
                            ctrl_wait_d = wdata_q[3:0];
                            wr_cnt_d    = wr_cnt_q + DATA_WIDTH'(1);
                        end
                        OFF_WRCNT:  wr_cnt_d  = '0;
                        OFF_RDCNT:  rd_cnt_d  = '0;
                        OFF_ERRCNT: err_cnt_d = '0;
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pwrite_q    <= 1'b0;
            wdata_q     <= '0;
            reg_rdata_q <= '0;
            wcnt_q      <= '0;
            ctrl_wait_q <= 4'(WAIT_DEFAULT);
            dec_q       <= '0;
            ready_q     <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pwrite_q    <= pwrite_d;
            wdata_q     <= wdata_d;
            reg_rdata_q <= reg_rdata_d;
            wcnt_q      <= wcnt_d;
            ctrl_wait_q <= ctrl_wait_d;
            dec_q       <= dec_d;
            ready_q     <= ready_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // A master that abandons the access never sees a ready pulse.
    assign pready        = ready_q & access;
    assign bus.pready_o  = pready;
    assign bus.pslverr_o = pready & dec_q.is_err;
    assign bus.prdata_o  = (pready && !pwrite_q && !dec_q.is_err)
                           ? (dec_q.is_mem ? mem_rdata : reg_rdata_q) : '0;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: a reference model predicts each transfer's result.
module tb_apb_mem_slave;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    apb_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_LG2(8), .WAIT_DEFAULT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] err;
        int          cyc;
        bit          cmp_data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [int];
    int          m_wait;
    logic [31:0] m_wr, m_rd, m_err;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = '0;
        bus.pwdata_i  = '0;
    endtask

    task automatic model_reset();
        m_wait = 0;
        m_wr   = '0;
        m_rd   = '0;
        m_err  = '0;
    endtask

    function automatic bit is_err(input logic [11:0] a);
        return (a[1:0] != 2'b00) ||
               !((a <= 12'h3FF) || (a inside {12'hF00, 12'hF04, 12'hF08, 12'hF0C}));
    endfunction

    task automatic setup_phase(input bit wr, input logic [11:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = wr;
        bus.paddr_i   = {20'h0001F, a};
        bus.pwdata_i  = d;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
    endtask

    task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                        output logic [31:0] rd_got);
        exp_t e;
        bit   err, done;
        int   cyc;
        err        = is_err(a);
        e.err      = {31'b0, err};
        e.cyc      = m_wait + 1;
        e.rdata    = '0;
        e.cmp_data = 1'b1;
        if (!wr && !err) begin
            if (a <= 12'h3FF) begin
                if (m_mem.exists(int'(a >> 2))) e.rdata = m_mem[int'(a >> 2)];
                else                            e.cmp_data = 1'b0;
            end else begin
                case (a)
                    12'hF00: e.rdata = 32'(m_wait);
                    12'hF04: e.rdata = m_wr;
                    12'hF08: e.rdata = m_rd;
                    default: e.rdata = m_err;
                endcase
            end
        end
        sb.push_back(e);
        setup_phase(wr, a, d);
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc <= 40) begin
            @(negedge clk);
            if (bus.pready_o) done = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        e      = sb.pop_front();
        rd_got = bus.prdata_o;
        if (!done) chk("timeout", 32'(cyc), 32'(e.cyc));
        else begin
            chk(wr ? "wr_cycles" : "rd_cycles", 32'(cyc), 32'(e.cyc));
            chk("pslverr", {31'b0, bus.pslverr_o}, e.err);
            if (e.cmp_data) chk("prdata", bus.prdata_o, e.rdata);
        end
        if (err) m_err++;
        else if (!wr) m_rd++;
        else if (a <= 12'h3FF) begin
            m_mem[int'(a >> 2)] = d;
            m_wr++;
        end else begin
            case (a)
                12'hF00: begin m_wait = int'(d[3:0]); m_wr++; end
                12'hF04: m_wr  = '0;
                12'hF08: m_rd  = '0;
                default: m_err = '0;
            endcase
        end
        @(posedge clk); #1;
        idle_bus();
    endtask

    initial begin
        idle_bus();
        model_reset();
        rst_n = 1'b0;
        #12;
        chk("rst_pready", {31'b0, bus.pready_o}, 32'd0);
        chk("rst_pslverr", {31'b0, bus.pslverr_o}, 32'd0);
        chk("rst_prdata", bus.prdata_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic write/read with zero wait
        xfer(1, 12'h010, 32'hDEADBEEF, got);
        xfer(0, 12'h010, 32'h0, got);
        chk("rd_010", got, 32'hDEADBEEF);
        xfer(0, 12'hF08, 32'h0, got);
        chk("rdcnt_1", got, 32'd1);
        xfer(0, 12'hF04, 32'h0, got);
        chk("wrcnt_1", got, 32'd1);

        // wait states
        xfer(1, 12'h3FC, 32'hA5A50001, got);
        xfer(1, 12'hF00, 32'hFFFF_FFF3, got);
        xfer(0, 12'h3FC, 32'h0, got);
        xfer(0, 12'hF00, 32'h0, got);
        chk("ctrl_3", got, 32'h3);

        // error decode, then clear ERR_CNT
        xfer(0, 12'h400, 32'h0, got);
        xfer(1, 12'h011, 32'h55555555, got);
        xfer(0, 12'h010, 32'h0, got);
        chk("mem_kept", got, 32'hDEADBEEF);
        xfer(0, 12'hF0C, 32'h0, got);
        chk("errcnt_2", got, 32'd2);
        xfer(0, 12'hF10, 32'h0, got);
        xfer(1, 12'hF0C, 32'h0, got);
        xfer(0, 12'hF0C, 32'h0, got);
        chk("errcnt_clr", got, 32'd0);

        // penable without setup while idle is ignored
        @(posedge clk); #1;
        bus.psel_i = 1'b1; bus.penable_i = 1'b1; bus.paddr_i = 32'h0001F400;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_pen_rdy", {31'b0, bus.pready_o}, 32'd0);
        end
        @(posedge clk); #1;
        idle_bus();

        // abort in S_WAIT
        xfer(1, 12'hF00, 32'h5, got);
        setup_phase(0, 12'h010, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_rdy", {31'b0, bus.pready_o}, 32'd0);
            @(posedge clk); #1;
        end
        idle_bus();
        m_err++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_idle_rdy", {31'b0, bus.pready_o}, 32'd0);
        end
        xfer(0, 12'hF0C, 32'h0, got);
        chk("errcnt_abort", got, 32'd1);

        // maximum wait
        xfer(1, 12'hF00, 32'hF, got);
        xfer(0, 12'h010, 32'h0, got);

        // four-beat burst as the bridge would issue it
        xfer(1, 12'hF00, 32'h0, got);
        xfer(1, 12'hF04, 32'h0, got);
        for (int i = 0; i < 4; i++) xfer(1, 12'(12'h100 + 4*i), 32'hB0B0_0000 + 32'(i), got);
        for (int i = 0; i < 4; i++) begin
            xfer(0, 12'(12'h100 + 4*i), 32'h0, got);
            chk("burst_rd", got, 32'hB0B0_0000 + 32'(i));
        end
        xfer(0, 12'hF04, 32'h0, got);
        chk("wrcnt_4", got, 32'd4);

        // reset in the middle of a waited write
        xfer(1, 12'h020, 32'h11111111, got);
        xfer(1, 12'hF00, 32'h2, got);
        setup_phase(1, 12'h020, 32'h22222222);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_pready", {31'b0, bus.pready_o}, 32'd0);
        chk("rstw_pslverr", {31'b0, bus.pslverr_o}, 32'd0);
        idle_bus();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        // reset while pready is high drops outputs at once
        setup_phase(0, 12'h020, 32'h0);
        @(negedge clk);
        chk("pre_rst_rdy", {31'b0, bus.pready_o}, 32'd1);
        chk("pre_rst_data", bus.prdata_o, 32'h11111111);
        #1 rst_n = 1'b0;
        #1;
        chk("rstr_pready", {31'b0, bus.pready_o}, 32'd0);
        chk("rstr_prdata", bus.prdata_o, 32'd0);
        idle_bus();
        @(posedge clk); #1;
        rst_n = 1'b1;

        xfer(0, 12'hF00, 32'h0, got);
        chk("ctrl_default", got, 32'd0);
        xfer(0, 12'h020, 32'h0, got);
        chk("no_commit", got, 32'h11111111);
        xfer(0, 12'hF04, 32'h0, got);
        chk("wrcnt_rst", got, 32'd0);
        xfer(0, 12'hF0C, 32'h0, got);
        chk("errcnt_rst", got, 32'd0);
        xfer(0, 12'hF08, 32'h0, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
